cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single result writeback path (common data bus, CDB) among NREQ execution units: ALU/RS, LSB load and branch unit.
- Each unit hands results to a private 2-entry queue. One round-robin grant per cycle broadcasts a registered {rob_id, value, src} to the ROB, RS and LSB wakeup logic.
- A branch-mispredict clear flushes all queued results.

Parameters:
- NREQ, 3: number of requesters; legal values are 2 to 4.
- ROB_WIDTH, 4: width of a ROB index.
- SRC_W, 2: width of cdb_src; must be at least ceil(log2 NREQ).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- rdy_in  input  1  global ready; when low, the block freezes.
- clear  input  1  mispredict flush, sampled only when rdy_in is high.
- req_valid  input  NREQ  per-requester result valid.
- req_ready  output  NREQ  per-requester queue can accept.
- req_rob_id  input  NREQ*ROB_WIDTH  packed result ROB ids; requester i occupies bits [i*ROB_WIDTH +: ROB_WIDTH].
- req_value  input  NREQ*32  packed result values; requester i occupies bits [i*32 +: 32].
- cdb_valid  output  1  registered broadcast valid.
- cdb_rob_id  output  ROB_WIDTH  registered broadcast ROB id.
- cdb_value  output  32  registered broadcast value.
- cdb_src  output  SRC_W  index of the requester that was granted.
- busy  output  1  high when any queue is non-empty.

Behaviour:
- Reset (asynchronous, rst_in high): all queue counts and pointers = 0; rr_ptr = 0; cdb_valid = 0; cdb_rob_id = 0; cdb_value = 0; cdb_src = 0.
- Queues: one 2-entry FIFO per requester, each with a 1-bit read pointer, a 1-bit write pointer and a 2-bit count.
- req_ready[i] = rdy_in && !clear && (count[i] < 2). It is combinational and never depends on req_valid.
- Push: on a clock edge where rdy_in && req_valid[i] && req_ready[i], the entry is written at wr_ptr[i].
- Simultaneous push and pop on the same queue is legal; the count is unchanged.
- Arbitration (combinational, evaluated each cycle with rdy_in && !clear):
  - Scan indices rr_ptr, rr_ptr+1, ... modulo NREQ.
  - The first index with a non-empty queue is granted.
  - Only the queue head is eligible. Data pushed in the same cycle is not eligible.
- Grant edge:
  - Pop the head of the granted queue.
  - cdb_valid <= 1; cdb_rob_id, cdb_value <= head fields; cdb_src <= granted index.
  - rr_ptr <= (grant + 1) mod NREQ.
- No grant (all queues empty): cdb_valid <= 0. cdb_rob_id, cdb_value and cdb_src hold their values. rr_ptr holds.
- Latency: an entry accepted at edge E broadcasts no earlier than the cycle after edge E+1. With no contention, that is exactly one cycle after edge E+1.
- Throughput: exactly one broadcast per cycle while busy.
- Ordering: FIFO order per requester; no ordering is guaranteed across requesters.
- Fairness: a continuously non-empty queue waits at most NREQ-1 grants.
- Clear (clear && rdy_in at an edge):
  - All counts and pointers = 0; rr_ptr = 0; cdb_valid <= 0.
  - Pushes in that cycle are dropped (req_ready is already low).
  - Clear has priority over push and grant.
- rdy_in low: all state and outputs hold, including cdb_valid. req_ready = 0. clear is ignored.
- Reset mid-operation: asynchronous clear to the reset values. Queued results are lost.
- busy = OR over all (count != 0).
- Full queue: req_ready[i] = 0. The requester must hold req_valid and its data until accepted.
- rr_ptr wrap-around: rr_ptr stays in range 0..NREQ-1 for NREQ values that are not a power of two.

Test Plan:
- Single result: cycle 0 pushes req 1 {rob 5, 0x1234}, other queues empty. Required: cdb_valid is high for exactly the one cycle after edge 1, with rob_id = 5, value = 0x1234, src = 1; then cdb_valid = 0 and busy = 0.
- Round-robin: pushes to reqs 0, 1, 2 in the same cycle with rob ids 1, 2, 3 and rr_ptr = 0. Required: broadcasts on 3 consecutive cycles in src order 0, 1, 2. A further push to req 0 alone then broadcasts with src = 0.
- Backpressure: req 2 pushes every cycle while req 0 holds two entries. Required: req_ready[2] drops once count reaches 2. Grants alternate between 0 and 2, so req 2 never waits more than 2 grants. No entry is lost or duplicated; all rob ids are checked.
- Flush: 2 entries are queued in each of reqs 0 and 1, then clear is pulsed for 1 cycle. Required: the next edge gives cdb_valid = 0 and busy = 0, and req_ready is 0 during the clear cycle. A later push {rob 9} broadcasts normally with src unaffected by the flushed data.
- Stall: with 3 entries queued, rdy_in is held low for 4 cycles in the middle of the sequence. Required: cdb outputs frozen, including cdb_valid = 1 if it was high, and req_ready = 0. After rdy_in returns, the remaining entries drain in the same order as without the stall.
- Async reset: rst_in asserted between clock edges while busy. Required: cdb_valid = 0 and busy = 0 immediately, before the next edge, and all queues are empty afterwards.

Source files
------------

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the single result writeback bus (CDB) among NREQ execution units.
//
// Each requester pushes results into a private 2-entry FIFO. Every cycle one non-empty
// queue head is granted round-robin and broadcast as a registered {rob_id, value, src}.
// A mispredict clear flushes every queue. While rdy_in is low the whole block freezes.
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous active-high reset
//   rdy_in      global ready; low freezes all state and outputs
//   clear       mispredict flush (only honoured when rdy_in is high)
//   req_valid   per-requester result valid
//   req_ready   per-requester queue can accept (combinational)
//   req_rob_id  packed ROB ids, requester i at [i*ROB_WIDTH +: ROB_WIDTH]
//   req_value   packed values, requester i at [i*32 +: 32]
//   cdb_valid   registered broadcast valid
//   cdb_rob_id  registered broadcast ROB id
//   cdb_value   registered broadcast value
//   cdb_src     index of the granted requester
//   busy        any queue non-empty
module cdb_arbiter #(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned SRC_W     = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      clear,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*ROB_WIDTH-1:0] req_rob_id,
    input  logic [NREQ*32-1:0]        req_value,
    output logic                      cdb_valid,
    output logic [ROB_WIDTH-1:0]      cdb_rob_id,
    output logic [31:0]               cdb_value,
    output logic [SRC_W-1:0]          cdb_src,
    output logic                      busy
);

    logic                      active;
    logic [NREQ-1:0][1:0]      cnt_q, cnt_d;
    logic [NREQ-1:0]           rd_ptr_q, rd_ptr_d;
    logic [NREQ-1:0]           wr_ptr_q, wr_ptr_d;
    logic [ROB_WIDTH-1:0]      rob_mem_q [NREQ][2];
    logic [31:0]               val_mem_q [NREQ][2];
    logic [SRC_W-1:0]          rr_ptr_q, rr_ptr_d;

    logic                      cdb_valid_q, cdb_valid_d;
    logic [ROB_WIDTH-1:0]      cdb_rob_id_q, cdb_rob_id_d;
    logic [31:0]               cdb_value_q, cdb_value_d;
    logic [SRC_W-1:0]          cdb_src_q, cdb_src_d;

    logic [NREQ-1:0]           nonempty;
    logic [NREQ-1:0]           push;
    logic [NREQ-1:0]           pop;
    logic [2*NREQ-1:0]         ne_rot;
    logic                      gnt_valid;
    logic [SRC_W:0]            gnt_sum;
    logic [SRC_W-1:0]          gnt_idx;
    logic [SRC_W:0]            rr_next;
    logic [ROB_WIDTH-1:0]      head_rob;
    logic [31:0]               head_val;

    assign active = rdy_in && !clear;

    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            nonempty[i]  = (cnt_q[i] != 2'd0);
            req_ready[i] = active && (cnt_q[i] < 2'd2);
            push[i]      = req_valid[i] && req_ready[i];
        end
    end

    assign busy = |nonempty;

    // Rotate the non-empty mask so bit 0 is the requester at rr_ptr; the lowest set bit
    // of the rotated view is the round-robin winner. Only registered counts are looked at,
    // so entries pushed this cycle cannot be granted yet.
    always_comb begin
        ne_rot    = {nonempty, nonempty} >> rr_ptr_q;
        gnt_valid = 1'b0;
        gnt_sum   = '0;
        for (int k = int'(NREQ) - 1; k >= 0; k--) begin
            if (ne_rot[k]) begin
                gnt_valid = 1'b1;
                gnt_sum   = {1'b0, rr_ptr_q} + (SRC_W + 1)'(k);
            end
        end
        if (gnt_sum >= (SRC_W + 1)'(NREQ)) begin
            gnt_sum = gnt_sum - (SRC_W + 1)'(NREQ);
        end
        gnt_idx = gnt_sum[SRC_W-1:0];

        // Keeps rr_ptr inside 0..NREQ-1 even when NREQ is not a power of two.
        rr_next = {1'b0, gnt_idx} + (SRC_W + 1)'(1);
        if (rr_next >= (SRC_W + 1)'(NREQ)) begin
            rr_next = '0;
        end
    end

    always_comb begin
        head_rob = '0;
        head_val = '0;
        pop      = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                head_rob = rob_mem_q[i][rd_ptr_q[i]];
                head_val = val_mem_q[i][rd_ptr_q[i]];
                pop[i]   = active && gnt_valid;
            end
        end
    end

    // Queue bookkeeping; push and pop on the same queue leave the count unchanged.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            if (rdy_in && clear) begin
                cnt_d[i]    = 2'd0;
                rd_ptr_d[i] = 1'b0;
                wr_ptr_d[i] = 1'b0;
            end else begin
                cnt_d[i]    = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
                rd_ptr_d[i] = rd_ptr_q[i] ^ pop[i];
                wr_ptr_d[i] = wr_ptr_q[i] ^ push[i];
            end
        end
    end

    always_comb begin
        cdb_valid_d  = cdb_valid_q;
        cdb_rob_id_d = cdb_rob_id_q;
        cdb_value_d  = cdb_value_q;
        cdb_src_d    = cdb_src_q;
        rr_ptr_d     = rr_ptr_q;
        if (rdy_in) begin
            if (clear) begin
                cdb_valid_d = 1'b0;
                rr_ptr_d    = '0;
            end else if (gnt_valid) begin
                cdb_valid_d  = 1'b1;
                cdb_rob_id_d = head_rob;
                cdb_value_d  = head_val;
                cdb_src_d    = gnt_idx;
                rr_ptr_d     = rr_next[SRC_W-1:0];
            end else begin
                cdb_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q        <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rr_ptr_q     <= '0;
            cdb_valid_q  <= 1'b0;
            cdb_rob_id_q <= '0;
            cdb_value_q  <= '0;
            cdb_src_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_rob_id_q <= cdb_rob_id_d;
            cdb_value_q  <= cdb_value_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    // Payload storage needs no reset: an entry is only read once its count says it is valid.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < int'(NREQ); i++) begin
            if (push[i]) begin
                rob_mem_q[i][wr_ptr_q[i]] <= req_rob_id[i*ROB_WIDTH +: ROB_WIDTH];
                val_mem_q[i][wr_ptr_q[i]] <= req_value[i*32 +: 32];
            end
        end
    end

    assign cdb_valid  = cdb_valid_q;
    assign cdb_rob_id = cdb_rob_id_q;
    assign cdb_value  = cdb_value_q;
    assign cdb_src    = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios followed by a randomized run, all checked against a
// queue-level reference model of the CDB arbiter (per-requester lists, modular round-robin).
module tb_cdb_arbiter;

    localparam int NREQ = 3;
    localparam int RW   = 4;
    localparam int SW   = 2;

    logic                 clk_in;
    logic                 rst_in;
    logic                 rdy_in;
    logic                 clear;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*RW-1:0]   req_rob_id;
    logic [NREQ*32-1:0]   req_value;
    logic                 cdb_valid;
    logic [RW-1:0]        cdb_rob_id;
    logic [31:0]          cdb_value;
    logic [SW-1:0]        cdb_src;
    logic                 busy;

    cdb_arbiter #(
        .NREQ      (NREQ),
        .ROB_WIDTH (RW),
        .SRC_W     (SW)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rob_id (req_rob_id),
        .req_value  (req_value),
        .cdb_valid  (cdb_valid),
        .cdb_rob_id (cdb_rob_id),
        .cdb_value  (cdb_value),
        .cdb_src    (cdb_src),
        .busy       (busy)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks;
    int n_pass;

    // Reference model: each requester owns a list of at most two entries, head at slot 0.
    logic [RW-1:0] mrob [NREQ][2];
    logic [31:0]   mval [NREQ][2];
    int            mcnt [NREQ];
    int            m_rr;
    logic          m_valid;
    logic [RW-1:0] m_rob;
    logic [31:0]   m_val;
    int            m_src;

    logic [NREQ-1:0] acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic m_busy();
        logic b = 1'b0;
        for (int i = 0; i < NREQ; i++) b = b | (mcnt[i] != 0);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
        m_rr    = 0;
        m_valid = 1'b0;
        m_rob   = '0;
        m_val   = '0;
        m_src   = 0;
    endtask

    task automatic set_req(input int i, input logic [RW-1:0] rob, input logic [31:0] val);
        req_rob_id[i*RW +: RW] = rob;
        req_value[i*32 +: 32]  = val;
    endtask

    // One clock: drive at the falling edge, check combinational outputs, advance the model,
    // then check the registered outputs just after the rising edge.
    task automatic cycle(input logic rdy, input logic clr, input logic [NREQ-1:0] vld,
                         output logic [NREQ-1:0] accepted);
        logic [NREQ-1:0] er;
        int g;
        int idx;
        rdy_in    = rdy;
        clear     = clr;
        req_valid = vld;
        #1;
        for (int i = 0; i < NREQ; i++) er[i] = rdy && !clr && (mcnt[i] < 2);
        accepted = er & vld;
        check("req_ready", 64'(req_ready), 64'(er));
        check("busy_pre", 64'(busy), 64'(m_busy()));
        if (rdy && clr) begin
            for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
            m_rr    = 0;
            m_valid = 1'b0;
        end else if (rdy) begin
            g = -1;
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (g < 0 && mcnt[idx] > 0) g = idx;
            end
            if (g >= 0) begin
                m_valid    = 1'b1;
                m_rob      = mrob[g][0];
                m_val      = mval[g][0];
                m_src      = g;
                mrob[g][0] = mrob[g][1];
                mval[g][0] = mval[g][1];
                mcnt[g]--;
                m_rr = (g + 1) % NREQ;
            end else begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (accepted[i]) begin
                    mrob[i][mcnt[i]] = req_rob_id[i*RW +: RW];
                    mval[i][mcnt[i]] = req_value[i*32 +: 32];
                    mcnt[i]++;
                end
            end
        end
        @(posedge clk_in);
        #1;
        check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
        check("cdb_rob_id", 64'(cdb_rob_id), 64'(m_rob));
        check("cdb_value", 64'(cdb_value), 64'(m_val));
        check("cdb_src", 64'(cdb_src), 64'(m_src));
        check("busy_post", 64'(busy), 64'(m_busy()));
        @(negedge clk_in);
    endtask

    int  s0;
    int  s2;
    logic seen_full;

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        rst_in     = 1'b1;
        rdy_in     = 1'b0;
        clear      = 1'b0;
        req_valid  = '0;
        req_rob_id = '0;
        req_value  = '0;
        model_reset();

        #2;
        check("rst_valid", 64'(cdb_valid), 64'd0);
        check("rst_rob", 64'(cdb_rob_id), 64'd0);
        check("rst_value", 64'(cdb_value), 64'd0);
        check("rst_src", 64'(cdb_src), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Single result: visible exactly one cycle after the edge following acceptance.
        set_req(1, 4'd5, 32'h1234);
        cycle(1'b1, 1'b0, 3'b010, acc);
        check("single_latency", 64'(cdb_valid), 64'd0);
        cycle(1'b1, 1'b0, 3'b000, acc);
        check("single_valid", 64'(cdb_valid), 64'd1);
        check("single_rob", 64'(cdb_rob_id), 64'd5);
        check("single_value", 64'(cdb_value), 64'h1234);
        check("single_src", 64'(cdb_src), 64'd1);
        cycle(1'b1, 1'b0, 3'b000, acc);
        check("single_end", 64'({cdb_valid, busy}), 64'd0);

        // Round-robin from rr_ptr = 0 (a clear restores it).
        cycle(1'b1, 1'b1, 3'b000, acc);
        set_req(0, 4'd1, 32'hA0);
        set_req(1, 4'd2, 32'hA1);
        set_req(2, 4'd3, 32'hA2);
        cycle(1'b1, 1'b0, 3'b111, acc);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 3'b000, acc);
            check("rr_order", 64'(cdb_src), 64'(k));
        end
        set_req(0, 4'd4, 32'hB0);
        cycle(1'b1, 1'b0, 3'b001, acc);
        cycle(1'b1, 1'b0, 3'b000, acc);
        check("rr_again_src", 64'(cdb_src), 64'd0);
        cycle(1'b1, 1'b0, 3'b000, acc);

        // Backpressure: req 0 and req 2 push every cycle, each holding data until accepted.
        s0 = 0;
        s2 = 0;
        seen_full = 1'b0;
        for (int c = 0; c < 12; c++) begin
            set_req(0, 4'(s0), 32'h100 + 32'(s0));
            set_req(2, 4'(8 + s2), 32'h200 + 32'(s2));
            cycle(1'b1, 1'b0, 3'b101, acc);
            if (acc[0]) s0++;
            if (acc[2]) s2++;
            else seen_full = 1'b1;
        end
        check("bp_full_seen", 64'(seen_full), 64'd1);
        for (int c = 0; c < 5; c++) cycle(1'b1, 1'b0, 3'b000, acc);

        // Flush with two entries queued in reqs 0 and 1.
        for (int c = 0; c < 3; c++) begin
            set_req(0, 4'(c), 32'h300 + 32'(c));
            set_req(1, 4'(c + 4), 32'h400 + 32'(c));
            cycle(1'b1, 1'b0, 3'b011, acc);
        end
        cycle(1'b1, 1'b1, 3'b011, acc);
        check("flush_valid", 64'(cdb_valid), 64'd0);
        check("flush_busy", 64'(busy), 64'd0);
        set_req(2, 4'd9, 32'h999);
        cycle(1'b1, 1'b0, 3'b100, acc);
        cycle(1'b1, 1'b0, 3'b000, acc);
        check("flush_after_rob", 64'(cdb_rob_id), 64'd9);
        check("flush_after_src", 64'(cdb_src), 64'd2);
        cycle(1'b1, 1'b0, 3'b000, acc);

        // Stall mid-drain: outputs freeze, including a high cdb_valid.
        set_req(0, 4'd1, 32'h501);
        set_req(1, 4'd2, 32'h502);
        set_req(2, 4'd3, 32'h503);
        cycle(1'b1, 1'b0, 3'b111, acc);
        cycle(1'b1, 1'b0, 3'b000, acc);
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b1, 3'b111, acc);
            check("stall_valid", 64'(cdb_valid), 64'd1);
        end
        for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0, 3'b000, acc);

        // Asynchronous reset between edges while busy.
        cycle(1'b1, 1'b0, 3'b111, acc);
        cycle(1'b1, 1'b0, 3'b000, acc);
        #2;
        rst_in = 1'b1;
        #1;
        check("arst_valid", 64'(cdb_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        model_reset();
        #1;
        rst_in = 1'b0;
        @(negedge clk_in);
        cycle(1'b1, 1'b0, 3'b000, acc);
        check("arst_empty", 64'(busy), 64'd0);

        // Randomized traffic with occasional stalls and flushes.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 4'($urandom), $urandom);
            cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 39) == 0),
                  3'($urandom), acc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
